mesure_sequencer: RTL

Measurement controller for the ultrasonic rangefinder. It issues the sensor trigger pulse, waits for the echo, and times the echo width in distance units. It clamps the result and presents it with a one-cycle valid strobe. It sits between the sensor pins and the display/range consumer, and replaces free-running echo counting with a sequenced, timeout-protected cycle.

---
 rtl/mesure_sequencer_if.sv | 15 +
 rtl/mesure_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mesure_sequencer_if.sv
// Sensor/consumer handshake bundle for the ultrasonic measurement sequencer.
// The host or bench drives through master; the sequencer connects through slave.
interface mesure_sequencer_if;
    logic       Start;
    logic       Auto;
    logic       Echo;
    logic       Trig;
    logic [7:0] Nb;
    logic       Valid;
    logic       Busy;
    logic       Timeout;

    modport master (output Start, Auto, Echo, input Trig, Nb, Valid, Busy, Timeout);
    modport slave  (input Start, Auto, Echo, output Trig, Nb, Valid, Busy, Timeout);
endinterface

// File: rtl/mesure_sequencer.sv
// Ultrasonic rangefinder sequencer: trigger, echo wait, width timing, clamp, holdoff.
// Optional MESURE_AVG_EN: report the running mean of the last four good results.
module mesure_sequencer #(
    parameter int unsigned TRIG_CYCLES     = 500,
    parameter int unsigned CYCLES_PER_UNIT = 2900,
    parameter int unsigned TIMEOUT_CYCLES  = 1900000,
    parameter int unsigned HOLDOFF_CYCLES  = 3000000,
    parameter int unsigned NB_MIN          = 6,
    parameter int unsigned NB_MAX          = 254
) (
    input logic               Clk,
    input logic               Rst_n,
    mesure_sequencer_if.slave bus
);
    localparam int unsigned MAX_WAIT = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned MAX_CNT  = (MAX_WAIT > TRIG_CYCLES) ? MAX_WAIT : TRIG_CYCLES;
    localparam int unsigned CW       = $clog2(MAX_CNT + 1);
    localparam int unsigned SW       = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF} state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [SW-1:0]   sub_q, sub_nxt, sub_src, sub_step;
    logic [7:0]      dist_q, dist_nxt, dist_src, dist_step;
    logic [7:0]      nb_q, nb_nxt, sample;
    logic            to_q, to_nxt;
    logic            trig_q, valid_q, busy_q;
    logic            echo_m, echo_s, echo_d, echo_rise;
    logic            finish, finish_to;

    function automatic logic [7:0] clamp_nb(input logic [7:0] d);
        if (d < 8'(NB_MIN)) return 8'(NB_MIN);
        if (d > 8'(NB_MAX)) return 8'(NB_MAX);
        return d;
    endfunction

    assign echo_rise = echo_s & ~echo_d;
    assign sample    = clamp_nb(dist_q);

    // One echo-high cycle applied to the unit sub-counter; the rise cycle starts from zero.
    always_comb begin
        sub_src  = (state_q == MEASURE) ? sub_q  : '0;
        dist_src = (state_q == MEASURE) ? dist_q : '0;
        if (sub_src == SW'(CYCLES_PER_UNIT - 1)) begin
            sub_step  = '0;
            dist_step = (dist_src == 8'hFF) ? 8'hFF : dist_src + 8'd1;
        end else begin
            sub_step  = sub_src + SW'(1);
            dist_step = dist_src;
        end
    end

`ifdef MESURE_AVG_EN
    logic [7:0] hist_q [4];
    logic [7:0] hist_nxt [4];
    logic       filled_q, filled_nxt;
    logic [9:0] avg_sum;

    // Before the first good result the history is empty, so the mean is the sample itself.
    assign avg_sum = filled_q ? (10'(sample) + 10'(hist_q[0]) + 10'(hist_q[1]) + 10'(hist_q[2]))
                              : (10'(sample) << 2);
`endif

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        sub_nxt   = sub_q;
        dist_nxt  = dist_q;
        nb_nxt    = nb_q;
        to_nxt    = to_q;
        finish    = 1'b0;
        finish_to = 1'b0;
`ifdef MESURE_AVG_EN
        hist_nxt   = hist_q;
        filled_nxt = filled_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.Start || bus.Auto) begin
                    state_nxt = TRIG;
                    cnt_nxt   = '0;
                end
            end
            TRIG: begin
                if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                    state_nxt = WAIT_ECHO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = CW'(1);
                    sub_nxt   = sub_step;
                    dist_nxt  = dist_step;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    finish    = 1'b1;
                    finish_to = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            MEASURE: begin
                // cnt_q holds the echo width so far, including the rise cycle
                if (!echo_s) begin
                    finish = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    finish    = 1'b1;
                    finish_to = 1'b1;
                end else begin
                    cnt_nxt  = cnt_q + CW'(1);
                    sub_nxt  = sub_step;
                    dist_nxt = dist_step;
                end
            end
            DONE: begin
                state_nxt = HOLDOFF;
                cnt_nxt   = '0;
            end
            HOLDOFF: begin
                if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
                    state_nxt = bus.Auto ? TRIG : IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Result is committed on entry to DONE so Nb and Valid appear together.
        if (finish) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            to_nxt    = finish_to;
            if (finish_to) begin
                nb_nxt = 8'(NB_MAX);
            end else begin
`ifdef MESURE_AVG_EN
                nb_nxt      = 8'(avg_sum >> 2);
                hist_nxt[0] = sample;
                hist_nxt[1] = filled_q ? hist_q[0] : sample;
                hist_nxt[2] = filled_q ? hist_q[1] : sample;
                hist_nxt[3] = filled_q ? hist_q[2] : sample;
                filled_nxt  = 1'b1;
`else
                nb_nxt = sample;
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            dist_q  <= '0;
            nb_q    <= '0;
            to_q    <= 1'b0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            echo_m  <= 1'b0;
            echo_s  <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            sub_q   <= sub_nxt;
            dist_q  <= dist_nxt;
            nb_q    <= nb_nxt;
            to_q    <= to_nxt;
            trig_q  <= (state_nxt == TRIG);
            valid_q <= (state_nxt == DONE);
            busy_q  <= (state_nxt != IDLE);
            echo_m  <= bus.Echo;
            echo_s  <= echo_m;
            echo_d  <= echo_s;
        end
    end

`ifdef MESURE_AVG_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            filled_q <= 1'b0;
        end else begin
            hist_q   <= hist_nxt;
            filled_q <= filled_nxt;
        end
    end
`endif

    assign bus.Trig    = trig_q;
    assign bus.Nb      = nb_q;
    assign bus.Valid   = valid_q;
    assign bus.Busy    = busy_q;
    assign bus.Timeout = to_q;
endmodule
